// File: rtl/note_sequencer.sv
// note_sequencer: plays a melody from an internal song RAM.
// Drives the oscillator divider plus the envelope gate and trigger.
module note_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int DIV_W       = 11,
    parameter int DUR_W       = 5,
    parameter int TICK_PERIOD = 200000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DUR_W+DIV_W-1:0] wr_data,
    output logic [DIV_W-1:0]       osc_div,
    output logic                   osc_en,
    output logic                   env_gate,
    output logic                   env_trig,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      pos
);

    localparam int ENT_W  = DUR_W + DIV_W;
    localparam int TICK_W = $clog2(TICK_PERIOD);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
    localparam logic [DUR_W-1:0]  DUR_TWO   = DUR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        PLAY,
        DONE
    } state_t;

    state_t state;
    state_t state_d;

    logic [ENT_W-1:0]  mem [2**ADDR_W];
    logic [ENT_W-1:0]  rdata;
    logic [ADDR_W-1:0] addr;
    logic [TICK_W-1:0] tick;
    logic [DUR_W-1:0]  dur_cnt;
    logic              artic;

    logic [DUR_W-1:0]  ent_dur;
    logic [DIV_W-1:0]  ent_div;
    logic              is_end;
    logic              is_rest;
    logic              tick_wrap;
    logic              note_end;
    logic              last_addr;
    logic              idle_like;
    logic              go;

    assign ent_dur   = rdata[ENT_W-1:DIV_W];
    assign ent_div   = rdata[DIV_W-1:0];
    assign is_end    = (ent_dur == '0);
    assign is_rest   = (ent_div == '0);
    assign tick_wrap = (tick == TICK_LAST);
    assign note_end  = (state == PLAY) && tick_wrap && (dur_cnt == DUR_ONE);
    assign last_addr = (addr == '1);
    assign idle_like = (state == IDLE) || (state == DONE);
    assign go        = idle_like && start && !stop;
    assign busy      = !idle_like;
    assign done      = (state == DONE);

    // Song RAM: writes only while not playing, one read per FETCH.
    always_ff @(posedge clk) begin
        if (wr_en && idle_like) begin
            mem[wr_addr] <= wr_data;
        end
        if (state == FETCH) begin
            rdata <= mem[addr];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; stop beats every other condition while busy.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE, DONE: begin
                if (start && !stop) state_d = FETCH;
            end
            FETCH: begin
                state_d = stop ? IDLE : DECODE;
            end
            DECODE: begin
                if (stop)        state_d = IDLE;
                else if (is_end) state_d = loop ? FETCH : DONE;
                else             state_d = PLAY;
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (note_end) begin
                    state_d = (last_addr && !loop) ? DONE : FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: address, tempo counters and the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osc_div  <= '0;
            osc_en   <= 1'b0;
            env_gate <= 1'b0;
            env_trig <= 1'b0;
            pos      <= '0;
            addr     <= '0;
            tick     <= '0;
            dur_cnt  <= '0;
            artic    <= 1'b0;
        end else begin
            env_trig <= 1'b0;
            if (busy && stop) begin
                osc_en   <= 1'b0;
                env_gate <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (go) addr <= '0;
                    end
                    DECODE: begin
                        if (is_end) begin
                            osc_en   <= 1'b0;
                            env_gate <= 1'b0;
                            if (loop) addr <= '0;
                        end else begin
                            pos     <= addr;
                            dur_cnt <= ent_dur;
                            tick    <= '0;
                            if (is_rest) begin
                                osc_en   <= 1'b0;
                                env_gate <= 1'b0;
                                artic    <= 1'b0;
                            end else begin
                                osc_div  <= ent_div;
                                osc_en   <= 1'b1;
                                env_gate <= 1'b1;
                                env_trig <= 1'b1;
                                artic    <= (ent_dur >= DUR_TWO);
                            end
                        end
                    end
                    PLAY: begin
                        tick <= tick_wrap ? '0 : tick + TICK_ONE;
                        if (tick_wrap) dur_cnt <= dur_cnt - DUR_ONE;
                        // Gate low for the final tick-length of the note.
                        if (artic && dur_cnt == DUR_ONE && tick == TICK_ONE) begin
                            env_gate <= 1'b0;
                        end
                        if (note_end) begin
                            addr <= addr + ADDR_ONE;
                            if (last_addr && !loop) begin
                                osc_en   <= 1'b0;
                                env_gate <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench for note_sequencer.
// Edge-indexed playback model feeds a queue checked by a monitor.
module tb_note_sequencer;

    localparam int TP = 4;

    typedef struct packed {
        logic [10:0] div;
        logic        en;
        logic        gate;
        logic        trig;
        logic        busy;
        logic        done;
        logic [4:0]  pos;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, loop, wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [10:0] osc_div;
    logic        osc_en, env_gate, env_trig, busy, done;
    logic [4:0]  pos;

    int errors = 0;
    int checks = 0;

    out_t sb[$];

    logic [15:0] mmem [32] = '{default: '0};
    bit          m_play, m_done;
    int          m_a, m_n, m_D;
    logic [4:0]  m_dur;
    logic [10:0] m_divf;
    out_t        m_out;

    note_sequencer #(
        .ADDR_W(5), .DIV_W(11), .DUR_W(5), .TICK_PERIOD(TP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .loop(loop), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .osc_div(osc_div), .osc_en(osc_en),
        .env_gate(env_gate), .env_trig(env_trig), .busy(busy),
        .done(done), .pos(pos)
    );

    always #5 clk = ~clk;

    // Monitor: compare every cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        out_t e;
        out_t g;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            g = {osc_div, osc_en, env_gate, env_trig, busy, done, pos};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL sb @%0t: got div=%0d en=%b gate=%b trig=%b busy=%b done=%b pos=%0d want div=%0d en=%b gate=%b trig=%b busy=%b done=%b pos=%0d",
                         $time, g.div, g.en, g.gate, g.trig, g.busy, g.done, g.pos,
                         e.div, e.en, e.gate, e.trig, e.busy, e.done, e.pos);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic m_reset();
        m_play = 0;
        m_done = 0;
        m_a    = 0;
        m_n    = 0;
        m_out  = '0;
    endtask

    // Reference: position of each edge within the current entry decides output.
    task automatic model_edge();
        int c;
        if (!rst_n) begin
            m_reset();
            return;
        end
        m_out.trig = 1'b0;
        if (!m_play) begin
            if (wr_en) mmem[wr_addr] = wr_data;
            if (start && !stop) begin
                m_play = 1;
                m_done = 0;
                m_a    = 0;
                m_n    = 0;
            end
        end else if (stop) begin
            m_play     = 0;
            m_out.en   = 1'b0;
            m_out.gate = 1'b0;
        end else begin
            m_n++;
            if (m_n == 1) begin
                m_dur  = mmem[m_a][15:11];
                m_divf = mmem[m_a][10:0];
            end else if (m_n == 2) begin
                if (m_dur == 0) begin
                    m_out.en   = 1'b0;
                    m_out.gate = 1'b0;
                    if (loop) begin
                        m_a = 0;
                        m_n = 0;
                    end else begin
                        m_play = 0;
                        m_done = 1;
                    end
                end else begin
                    m_out.pos = 5'(m_a);
                    m_D = int'(m_dur) * TP;
                    if (m_divf != 0) begin
                        m_out.div  = m_divf;
                        m_out.en   = 1'b1;
                        m_out.gate = 1'b1;
                        m_out.trig = 1'b1;
                    end else begin
                        m_out.en   = 1'b0;
                        m_out.gate = 1'b0;
                    end
                end
            end else begin
                c = m_n - 1;
                if (m_divf != 0 && m_dur >= 2 && c > m_D + 2 - TP) begin
                    m_out.gate = 1'b0;
                end
                if (m_n == m_D + 2) begin
                    m_n = 0;
                    if (m_a == 31) begin
                        if (loop) begin
                            m_a = 0;
                        end else begin
                            m_play     = 0;
                            m_done     = 1;
                            m_out.en   = 1'b0;
                            m_out.gate = 1'b0;
                        end
                    end else begin
                        m_a++;
                    end
                end
            end
        end
        m_out.busy = m_play;
        m_out.done = m_done;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        sb.push_back(m_out);
        #1;
    endtask

    task automatic wr(int a, int d, int dv);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = {5'(d), 11'(dv)};
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic wait_trig(string nm);
        int k = 0;
        do begin
            step();
            k++;
        end while (env_trig !== 1'b1 && k < 200);
        chk({nm, " trig"}, 32'(env_trig), 1);
    endtask

    task automatic run_done(string nm, int budget);
        int k = 0;
        while (busy === 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk({nm, " idle"}, 32'(busy), 0);
    endtask

    function automatic int rnd_dur();
        return ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
    endfunction

    function automatic int rnd_div();
        return ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 2047));
    endfunction

    initial begin
        int lows, bad, cnt;
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        loop = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        m_reset();
        step();
        step();
        chk("rst div", 32'(osc_div), 0);
        chk("rst en", 32'(osc_en), 0);
        chk("rst gate", 32'(env_gate), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        rst_n = 1'b1;

        // Two notes then end marker.
        wr(0, 2, 298);
        wr(1, 1, 150);
        wr(2, 0, 0);
        pulse_start();
        step();
        chk("t1 trig k+1", 32'(env_trig), 0);
        step();
        chk("t1 trig k+2", 32'(env_trig), 1);
        chk("t1 div", 32'(osc_div), 298);
        chk("t1 pos", 32'(pos), 0);
        lows = 0;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (env_gate === 1'b0) lows++;
            if (osc_div !== 11'd298) bad++;
        end
        chk("t1 gate lows", 32'(lows), 4);
        chk("t1 div held", 32'(bad), 0);
        step();
        chk("t1 n2 div", 32'(osc_div), 150);
        chk("t1 n2 trig", 32'(env_trig), 1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (env_gate === 1'b1) cnt++;
        end
        chk("t1 n2 gate", 32'(cnt), 5);
        step();
        chk("t1 done", 32'(done), 1);
        chk("t1 busy", 32'(busy), 0);

        // Rest between two notes.
        wr(0, 2, 298);
        wr(1, 3, 0);
        wr(2, 1, 150);
        wr(3, 0, 0);
        pulse_start();
        wait_trig("t2 n1");
        for (int i = 0; i < 9; i++) step();
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (!osc_en && !env_gate && !env_trig && osc_div == 11'd298) cnt++;
        end
        chk("t2 rest cycles", 32'(cnt), 14);
        step();
        chk("t2 n3 trig", 32'(env_trig), 1);
        chk("t2 n3 div", 32'(osc_div), 150);
        run_done("t2", 50);

        // Loop back after end marker.
        wr(0, 2, 298);
        wr(1, 1, 150);
        wr(2, 0, 0);
        loop = 1'b1;
        pulse_start();
        for (int i = 0; i < 3; i++) wait_trig("t3 loop");
        chk("t3 loop div", 32'(osc_div), 298);
        chk("t3 loop pos", 32'(pos), 0);
        do_stop();
        loop = 1'b0;

        // Full table, no marker.
        for (int a = 0; a < 32; a++) wr(a, 1, 100 + a);
        pulse_start();
        run_done("t3 wrap", 32 * 6 + 20);
        chk("t3 wrap done", 32'(done), 1);
        chk("t3 wrap pos", 32'(pos), 31);
        loop = 1'b1;
        pulse_start();
        for (int i = 0; i < 33; i++) wait_trig("t3 wrap loop");
        chk("t3 wrap loop pos", 32'(pos), 0);
        chk("t3 wrap loop div", 32'(osc_div), 100);
        do_stop();
        loop = 1'b0;

        // Stop mid-note, then start+stop together.
        wr(0, 3, 200);
        wr(1, 0, 0);
        pulse_start();
        wait_trig("t4");
        step();
        do_stop();
        chk("t4 busy", 32'(busy), 0);
        chk("t4 en", 32'(osc_en), 0);
        chk("t4 gate", 32'(env_gate), 0);
        chk("t4 div", 32'(osc_div), 200);
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("t4 start+stop", 32'(busy), 0);
        step();
        chk("t4 still idle", 32'(busy), 0);

        // Write while busy is dropped.
        wr(0, 2, 298);
        wr(1, 0, 0);
        pulse_start();
        step();
        step();
        wr(0, 2, 111);
        run_done("t5", 50);
        pulse_start();
        wait_trig("t5 replay");
        chk("t5 replay div", 32'(osc_div), 298);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 arst en", 32'(osc_en), 0);
        chk("t5 arst gate", 32'(env_gate), 0);
        chk("t5 arst busy", 32'(busy), 0);
        chk("t5 arst div", 32'(osc_div), 0);
        sb.delete();
        m_reset();
        step();
        rst_n = 1'b1;
        step();

        // Random table and random control.
        for (int a = 0; a < 32; a++) wr(a, rnd_dur(), rnd_div());
        for (int i = 0; i < 10000; i++) begin
            start   = ($urandom_range(0, 19) == 0);
            stop    = ($urandom_range(0, 149) == 0);
            loop    = 1'($urandom_range(0, 1));
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = {5'(rnd_dur()), 11'(rnd_div())};
            step();
        end
        start = 1'b0;
        stop = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        #1;
        chk("sb drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
